// File: rtl/bus_requester.sv
// Requester-side agent for a two-input request/grant arbiter: takes an N-beat job,
// requests the shared resource, issues one beat per granted cycle, then releases.
module bus_requester #(
    parameter int LEN_W   = 4,
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    input  logic             grant,
    output logic             request,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_count,
    output logic             done,
    output logic             timeout_err,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    // Handshake: a job transfers on a rising clk edge where job_valid && job_ready;
    // a beat transfers in any cycle where beat_valid is high (XFER && grant).

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_nxt;
    logic [LEN_W-1:0] len_last;
    logic [LEN_W-1:0] beat_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic             request_nxt;
    logic             done_nxt;
    logic             timeout_nxt;

    assign len_last = len_q - LEN_W'(1);

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        beat_nxt    = beat_count;
        wait_nxt    = wait_cnt;
        done_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                wait_nxt = '0;
                beat_nxt = '0;
                if (job_valid) begin
                    len_nxt = job_len;
                    if (job_len == '0) begin
                        state_nxt = RELEASE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (grant) begin
                    state_nxt = XFER;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = RELEASE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    wait_nxt    = '0;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            XFER: begin
                // A dropped grant here is a stall: no beat, no timeout, counter holds.
                if (grant) begin
                    if (beat_count == len_last) begin
                        state_nxt = RELEASE;
                        beat_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        beat_nxt = beat_count + 1'b1;
                    end
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        request_nxt = (state_nxt == REQ) || (state_nxt == XFER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            len_q       <= '0;
            beat_count  <= '0;
            wait_cnt    <= '0;
            request     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            len_q       <= len_nxt;
            beat_count  <= beat_nxt;
            wait_cnt    <= wait_nxt;
            request     <= request_nxt;
            done        <= done_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    // Reset is synchronous, so gate the combinational handshakes while it is held low.
    assign job_ready  = reset && (state == IDLE);
    assign beat_valid = reset && (state == XFER) && grant;
    assign busy       = (state != IDLE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_bus_requester.sv
// Self-checking bench for bus_requester: directed jobs against a job-level trace model,
// plus a two-instance run behind a bench-side lock-until-release arbiter.
module tb_bus_requester;

    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;
    localparam int W       = 10;

    logic             clk;
    logic             reset;
    logic             job_valid, job_valid1;
    logic [LEN_W-1:0] job_len, job_len1;
    logic             job_ready0, job_ready1;
    logic             grant_drv, arb_mode;
    logic             g0, g1;
    logic             req0, req1;
    logic             bv0, bv1;
    logic [LEN_W-1:0] bc0, bc1;
    logic             done0, done1;
    logic             to0, to1;
    logic             busy0, busy1;
    logic [1:0]       st0, st1;

    int checks = 0;
    int fails  = 0;
    int dut_beats, dut_dones, dut_tos;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] trace_q[$];

    bus_requester u0 (
        .clk(clk), .reset(reset), .job_valid(job_valid), .job_len(job_len),
        .job_ready(job_ready0), .grant(g0), .request(req0), .beat_valid(bv0),
        .beat_count(bc0), .done(done0), .timeout_err(to0), .busy(busy0), .fsm_state(st0)
    );

    bus_requester u1 (
        .clk(clk), .reset(reset), .job_valid(job_valid1), .job_len(job_len1),
        .job_ready(job_ready1), .grant(g1), .request(req1), .beat_valid(bv1),
        .beat_count(bc1), .done(done1), .timeout_err(to1), .busy(busy1), .fsm_state(st1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter: fixed priority to port 0, grant held until the owner drops request.
    logic [1:0] owner;
    always @(posedge clk) begin
        if (!reset) owner <= 2'd0;
        else begin
            case (owner)
                2'd0: if (req0) owner <= 2'd1; else if (req1) owner <= 2'd2;
                2'd1: if (!req0) owner <= 2'd0;
                2'd2: if (!req1) owner <= 2'd0;
                default: owner <= 2'd0;
            endcase
        end
    end
    assign g0 = arb_mode ? (owner == 2'd1) : grant_drv;
    assign g1 = arb_mode && (owner == 2'd2);

    function automatic logic [W-1:0] mk(input logic req, input logic bv, input logic [3:0] bc,
                                        input logic dn, input logic te, input logic bz,
                                        input logic jr);
        return {req, bv, bc, dn, te, bz, jr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: walk the grant pattern through wait, transfer and release phases.
    task automatic build_trace(input int len, input logic [31:0] pat);
        int t;
        int waits;
        int b;
        trace_q.delete();
        t = 0;
        waits = 0;
        if (len == 0) begin
            trace_q.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        end else begin
            while (!pat[t] && waits < TIMEOUT) begin
                trace_q.push_back(mk(1, 0, 0, 0, 0, 1, 0));
                t++;
                waits++;
            end
            if (waits == TIMEOUT) begin
                trace_q.push_back(mk(0, 0, 0, 1, 1, 1, 0));
            end else begin
                trace_q.push_back(mk(1, 0, 0, 0, 0, 1, 0));
                t++;
                b = 0;
                while (b < len) begin
                    if (pat[t]) begin
                        trace_q.push_back(mk(1, 1, 4'(b), 0, 0, 1, 0));
                        b++;
                    end else begin
                        trace_q.push_back(mk(1, 0, 4'(b), 0, 0, 1, 0));
                    end
                    t++;
                end
                trace_q.push_back(mk(0, 0, 0, 1, 0, 1, 0));
            end
        end
    endtask

    function automatic int trace_beats();
        int n = 0;
        foreach (trace_q[i]) n += int'(trace_q[i][8]);
        return n;
    endfunction

    // scoreboard compare: every cycle with an expectation queued
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(negedge clk);
            if (bv0) dut_beats++;
            if (done0) dut_dones++;
            if (to0) dut_tos++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {req0, bv0, bc0, done0, to0, busy0, job_ready0};
                checks++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL cycle_outputs {req,bv,bc,done,to,busy,rdy}: got %b expected %b at %0t",
                             act_v, exp_v, $time);
                end
            end
        end
    end

    // driver: one job from an IDLE cycle; the grant pattern bit k is the grant k cycles after acceptance
    task automatic run_job(input int len, input logic [31:0] pat, input int exp_cycles,
                           input int exp_beats, input int exp_to);
        build_trace(len, pat);
        check("model_cycles", trace_q.size(), exp_cycles);
        check("model_beats", trace_beats(), exp_beats);
        dut_beats = 0;
        dut_dones = 0;
        dut_tos   = 0;
        job_valid = 1'b1;
        job_len   = 4'(len);
        grant_drv = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        foreach (trace_q[k]) begin
            @(posedge clk); #1;
            job_valid = 1'b1;
            job_len   = 4'd5;
            grant_drv = pat[k];
            exp_q.push_back(trace_q[k]);
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
        grant_drv = 1'b1;
        check("dut_beats", dut_beats, exp_beats);
        check("dut_done_pulses", dut_dones, 1);
        check("dut_timeout_pulses", dut_tos, exp_to);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        job_valid  = 1'b0;
        job_valid1 = 1'b0;
        job_len    = '0;
        job_len1   = '0;
        grant_drv  = 1'b0;
        arb_mode   = 1'b0;

        @(posedge clk); #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        reset = 1'b1;

        // basic, stall, timeout, empty, then a back-to-back short job
        run_job(3, 32'hFFFF_FFFF, 5, 3, 0);
        run_job(4, 32'hFFFF_FFE7, 8, 4, 0);
        run_job(2, 32'h0000_0000, 16, 0, 1);
        run_job(0, 32'hFFFF_FFFF, 1, 0, 0);
        run_job(1, 32'hFFFF_FFFF, 3, 1, 0);
        run_job(2, 32'hFFFF_FFFE, 5, 2, 0);

        // reset held for two edges in the middle of a len=5 transfer
        dut_dones = 0;
        job_valid = 1'b1;
        job_len   = 4'd5;
        grant_drv = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
        job_valid = 1'b0;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        @(posedge clk); #1;
        exp_q.push_back(mk(1, 1, 0, 0, 0, 1, 0));
        @(posedge clk); #1;
        exp_q.push_back(mk(1, 1, 1, 0, 0, 1, 0));
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.push_back(mk(1, 0, 2, 0, 0, 1, 0));
        @(posedge clk); #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        reset = 1'b1;
        grant_drv = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        check("reset_no_done", dut_dones, 0);

        // both ports issue len=2 jobs together behind the arbiter
        arb_mode   = 1'b1;
        job_valid  = 1'b1;
        job_len    = 4'd2;
        job_valid1 = 1'b1;
        job_len1   = 4'd2;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            job_valid  = 1'b0;
            job_valid1 = 1'b0;
            @(negedge clk);
            check($sformatf("arb_bv0_c%0d", c), bv0, (c == 2 || c == 3));
            check($sformatf("arb_bv1_c%0d", c), bv1, (c == 7 || c == 8));
            check($sformatf("arb_done0_c%0d", c), done0, (c == 4));
            check($sformatf("arb_done1_c%0d", c), done1, (c == 9));
            check($sformatf("arb_overlap_c%0d", c), bv0 && bv1, 0);
            if (c == 2 || c == 3) check($sformatf("arb_bc0_c%0d", c), bc0, c - 2);
            if (c == 7 || c == 8) check($sformatf("arb_bc1_c%0d", c), bc1, c - 7);
        end
        check("arb_timeout1", to1, 0);
        arb_mode = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
